// File: rtl/xor_reduce_mux_pkg.sv
// Shared types and helpers for the mux-built XOR/XNOR reduction pipeline.
// Optional frame accumulator: XOR_REDUCE_MUX_PIPE_ACCUM_EN.
package xor_reduce_mux_pkg;

  localparam logic MODE_XOR  = 1'b0;
  localparam logic MODE_XNOR = 1'b1;

  typedef struct packed {
    logic valid;
    logic mode;
    logic last;
  } xr_side_t;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux2.sv
// 2:1 mux primitive; the only combinational cell of the reduction tree.
module mux2 (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/xor_reduce_mux_pipe_xor2.sv
// Two-input XOR made of two mux2 cells: invert b, then select on a.
module xor2_via_mux
  import xor_reduce_mux_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic o
);

  logic nb;

  mux2 u_inv (
    .sel(b),
    .d0 (1'b1),
    .d1 (1'b0),
    .y  (nb)
  );

  mux2 u_sel (
    .sel(a),
    .d0 (b),
    .d1 (nb),
    .y  (o)
  );

endmodule

// File: rtl/xor_reduce_mux_pipe.sv
// Pipelined XOR/XNOR reduction with valid/ready and global-enable stall.
// Optional frame accumulator: XOR_REDUCE_MUX_PIPE_ACCUM_EN.
module xor_reduce_mux_pipe
  import xor_reduce_mux_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int REG_EVERY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
`ifdef XOR_REDUCE_MUX_PIPE_ACCUM_EN
  input  logic             in_last,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity
);

  localparam int LEVELS = clog2_min1(WIDTH);
  localparam int PW     = 1 << LEVELS;

  logic          adv;
  logic [PW-1:0] pad;
  xr_side_t      side_in;
  logic          side_unused;

  // Heap layout: node n has children 2n, 2n+1; leaves sit at PW..2PW-1.
  logic [2*PW-1:1] nd;
  xr_side_t        sd [0:LEVELS];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    pad = '0;
    if (in_valid) pad[WIDTH-1:0] = in_data;
  end

  always_comb begin
    side_in       = '0;
    side_in.valid = in_valid;
    side_in.mode  = in_valid ? in_mode : MODE_XOR;
`ifdef XOR_REDUCE_MUX_PIPE_ACCUM_EN
    side_in.last  = in_valid && in_last;
`endif
  end

  assign nd[2*PW-1:PW] = pad;
  assign sd[0]         = side_in;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int NO  = PW >> (k + 1);
    localparam bit BND = (((k + 1) % REG_EVERY) == 0) ||
                         (k == LEVELS - 1);

    for (genvar i = 0; i < NO; i++) begin : g_node
      localparam int N = NO + i;
      logic x;

      xor2_via_mux u_x (
        .a(nd[2*N]),
        .b(nd[2*N+1]),
        .o(x)
      );

      if (BND) begin : g_reg
        logic d;
        logic q;

        if (N == 1) begin : g_fin
          logic nx;
          mux2 u_inv (
            .sel(x),
            .d0 (1'b1),
            .d1 (1'b0),
            .y  (nx)
          );
          mux2 u_mode (
            .sel(sd[k].mode),
            .d0 (x),
            .d1 (nx),
            .y  (d)
          );
        end else begin : g_pass
          assign d = x;
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) q <= 1'b0;
          else if (adv) q <= d;
        end

        assign nd[N] = q;
      end else begin : g_comb
        assign nd[N] = x;
      end
    end

    if (BND) begin : g_sreg
      xr_side_t q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else if (adv) q <= sd[k];
      end

      assign sd[k+1] = q;
    end else begin : g_scomb
      assign sd[k+1] = sd[k];
    end
  end

  assign out_valid = sd[LEVELS].valid;

`ifdef XOR_REDUCE_MUX_PIPE_ACCUM_EN
  logic acc;
  logic acc_x;

  xor2_via_mux u_acc (
    .a(acc),
    .b(nd[1]),
    .o(acc_x)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= 1'b0;
    else if (out_valid && out_ready)
      acc <= sd[LEVELS].last ? 1'b0 : acc_x;
  end

  assign out_parity  = acc_x;
  assign side_unused = sd[LEVELS].mode;
`else
  assign out_parity  = nd[1];
  assign side_unused = sd[LEVELS].mode ^ sd[LEVELS].last;
`endif

endmodule

// File: doc/xor_reduce_mux_pipe.md
Name: xor_reduce_mux_pipe

Overview:
- Parametrised, pipelined XOR/XNOR reduction (parity) unit.
- The combinational datapath is built only from 2:1 mux primitives; every 2-input XOR is two mux instances plus constants.
- Adds a valid/ready stream interface, per-level pipeline registers, backpressure and a runtime XOR/XNOR mode.
- Serves as the parity generator/checker in front of downstream stream blocks.

Parameters:
- WIDTH, 8, number of input bits reduced; legal range 1..64.
- REG_EVERY, 1, pipeline register inserted after every REG_EVERY tree levels; legal range 1..LEVELS.

Ports:
- clk  input  1  clock; all registers on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- in_data  input  WIDTH  bits to reduce.
- in_mode  input  1  0 = XOR (even parity → 0), 1 = XNOR.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_parity  output  1  reduced result.

Behaviour:
- LEVELS = clog2(WIDTH), minimum 1.
- Input is zero-padded to 2^LEVELS bits; zero is the XOR identity.
- Tree level k pairs adjacent bits through an xor2_via_mux instance.
- Register stages: NSTAGE = ceil(LEVELS / REG_EVERY).
- Latency: exactly NSTAGE cycles from an accepted input beat to out_valid, with no stalls.
- Mode travels with the data as a sideband bit in every stage.
- The final XNOR inversion is a mux at the last stage: sel = mode, d0 = x, d1 = ~x, built from mux constants.
- Stall model is a global enable: adv = !out_valid || out_ready.
  - When adv = 1, all stages shift.
  - in_ready = adv (combinational).
- A beat transfers when in_valid && in_ready.
- A bubble (in_valid = 0) shifts a valid = 0 into stage 0.
- Full throughput: one beat per cycle while out_ready = 1.
- Backpressure: while out_valid && !out_ready, every stage holds, in_ready = 0, and out_parity stays stable.
- Simultaneous output handshake and input accept in one cycle is legal. The pipeline shifts with no lost or duplicated beats.
- Reset (asynchronous, at any time, including mid-stream):
  - All stage valids → 0, out_valid → 0, out_parity → 0, mode sidebands → 0.
  - Data registers are reset to 0.
  - In-flight beats are discarded.
  - First accept is possible on the first clock after rst_n deasserts.
- in_data and in_mode are ignored when in_valid = 0.
- No X may propagate to out_parity while out_valid = 0.

Optional Feature:
- Macro: XOR_REDUCE_MUX_PIPE_ACCUM_EN.
- When defined, adds input port in_last (1 bit, travels as a sideband) and an output accumulator register acc.
  - Each output beat with valid updates acc = acc XOR result; out_parity = acc XOR result.
  - When the beat's last = 1, acc clears to 0 on the handshake.
  - acc holds while stalled.
  - Reset clears acc.
  - Result: frame parity across multiple beats; out_parity is meaningful on the last beat.
- When undefined: no in_last port, no accumulator, per-beat parity only.

Decomposition:
- Package xor_reduce_mux_pkg holds:
  - function clog2_min1(int) → int;
  - localparam MODE_XOR = 1'b0, MODE_XNOR = 1'b1;
  - typedef struct packed {logic valid; logic mode; logic last;} xr_side_t.
- Sub-module xor2_via_mux (a, b → o): two mux instances only (invert b, then select on a); instantiated by generate loops per tree level.
- The 2:1 mux primitive is reused unchanged.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with in_valid = 1 → out_valid = 0 and out_parity = 0 throughout. The first beat after release appears exactly NSTAGE cycles later.
- Basic parity, WIDTH = 8, mode 0, out_ready = 1:
  - in_data = 8'hA5 → 0;
  - 8'h01 → 1;
  - 8'hFF → 0.
  - Mode 1 on the same inputs → 1, 0, 1.
- Back-to-back stream of 16 random beats with out_ready = 1 → 16 results in order, one per cycle, matching the model ^in_data ^ mode.
- Backpressure: out_ready = 0 for 5 cycles once out_valid rises → in_ready = 0 and out_parity is stable. On release, beats drain in order with none lost or duplicated.
- Odd widths:
  - WIDTH = 5: in_data = 5'b10110 → 1.
  - WIDTH = 1: in_data = 1 → 1, latency 1.
  - WIDTH = 64: all-ones → 0.
- ACCUM_EN build: three beats 8'h01, 8'h03, 8'h07 with last on the third → out_parity = 1, 1, 0. The next frame starts with acc = 0.
- Mid-stream reset with 3 beats in flight → no stale result appears after reset.
